// File: rtl/net_seq_pkg.sv
// Shared types for the conv-network layer sequencer: FSM state encoding and
// index-width helpers.
package net_seq_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StShiftIn  = 3'd1,
    StStartL   = 3'd2,
    StWaitL    = 3'd3,
    StCacheL   = 3'd4,
    StLatchOut = 3'd5
  } state_e;

  localparam int unsigned NLayersDefault = 3;
  localparam int unsigned LayerW         = $clog2(NLayersDefault);

  // Layer index width for an arbitrary layer count, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Brings the asynchronous sample clock into the clk domain and turns each of
// its rising edges into a single-cycle tick.
module tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

endmodule

// File: rtl/net_layer_sequencer.sv
// Per-sample forward-pass scheduler: shifts the input, runs each conv layer in
// turn with a timeout, clocks the activation caches and latches the output.
module net_layer_sequencer
  import net_seq_pkg::*;
#(
  parameter int unsigned N_LAYERS = 3,
  parameter int unsigned TIMEOUT  = 1023,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic                enable,
  input  logic                clear_stats,
  output logic                lsb_shift,
  output logic [N_LAYERS-1:0] conv_start,
  input  logic [N_LAYERS-1:0] conv_done,
  output logic [N_LAYERS-2:0] cache_shift,
  output logic                out_latch,
  output logic                busy,
  output logic                err_timeout,
  output logic [CNT_W-1:0]    overrun_cnt,
  output logic [CNT_W-1:0]    pass_cycles,
  output logic [CNT_W-1:0]    max_pass_cycles
);

  localparam int unsigned LIdxW  = idx_w(N_LAYERS);
  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);
  localparam int unsigned NCache = N_LAYERS - 1;

  logic             tick;
  state_e           state_q;
  logic [LIdxW-1:0] layer_q;
  logic [WaitW-1:0] wait_q;
  logic [CNT_W-1:0] pass_cnt_q;

  logic done_ok, timeout_hit, last_layer, start_ok, drop;

  tick_sync u_tick_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sample_clk),
    .tick     (tick)
  );

  // wait_q is zero in the first WAIT cycle, where out_v may still be stale.
  assign done_ok     = (wait_q != '0) && conv_done[layer_q];
  assign timeout_hit = (state_q == StWaitL) && !done_ok && (wait_q == WaitW'(TIMEOUT - 1));
  assign last_layer  = (layer_q == LIdxW'(N_LAYERS - 1));
  assign start_ok    = tick && enable && (state_q == StIdle);
  assign drop        = tick && enable && (state_q != StIdle);

  // Outputs are registered from the transition into each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      layer_q     <= '0;
      wait_q      <= '0;
      pass_cnt_q  <= '0;
      lsb_shift   <= 1'b0;
      conv_start  <= '0;
      cache_shift <= '0;
      out_latch   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      lsb_shift   <= 1'b0;
      conv_start  <= '0;
      cache_shift <= '0;
      out_latch   <= 1'b0;
      if (state_q != StIdle && pass_cnt_q != '1) begin
        pass_cnt_q <= pass_cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q    <= StShiftIn;
            layer_q    <= '0;
            pass_cnt_q <= CNT_W'(1);
            lsb_shift  <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StShiftIn: begin
          state_q    <= StStartL;
          conv_start <= N_LAYERS'(1) << layer_q;
        end
        StStartL: begin
          state_q <= StWaitL;
          wait_q  <= '0;
        end
        StWaitL: begin
          if (done_ok) begin
            if (last_layer) begin
              state_q   <= StLatchOut;
              out_latch <= 1'b1;
            end else begin
              state_q     <= StCacheL;
              cache_shift <= NCache'(1) << layer_q;
            end
          end else if (timeout_hit) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StCacheL: begin
          state_q    <= StStartL;
          layer_q    <= layer_q + LIdxW'(1);
          conv_start <= N_LAYERS'(1) << (layer_q + LIdxW'(1));
        end
        StLatchOut: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Statistics; clear_stats overrides any same-cycle update except pass_cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt     <= '0;
      pass_cycles     <= '0;
      max_pass_cycles <= '0;
      err_timeout     <= 1'b0;
    end else begin
      if (state_q == StLatchOut) begin
        pass_cycles <= pass_cnt_q;
      end
      if (clear_stats) begin
        overrun_cnt     <= '0;
        max_pass_cycles <= '0;
        err_timeout     <= 1'b0;
      end else begin
        if (drop && overrun_cnt != '1) begin
          overrun_cnt <= overrun_cnt + CNT_W'(1);
        end
        if (state_q == StLatchOut && pass_cnt_q > max_pass_cycles) begin
          max_pass_cycles <= pass_cnt_q;
        end
        if (timeout_hit) begin
          err_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
